reg_bank: RTL
=============

Name: reg_bank

Overview:
- Parametrised successor to the single 16-bit function-select register.
- Holds NUM_REGS registers of WIDTH bits each. Each register is written through the same 3-bit FunSel operation set, generalised to any even width.
- Every register carries a sticky per-register wrap flag.
- Two combinational read ports feed the ALU and address muxes of the datapath.

Parameters:
- WIDTH, 16, register width in bits; must be even and >= 4. HALF = WIDTH/2.
- NUM_REGS, 4, number of registers; >= 2.
- SELW, $clog2(NUM_REGS), width of the read-select inputs (derived).
- RESET_VAL, 0, value loaded into every register on reset.

Ports:
- Clock  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-low reset
- RegSel  input  NUM_REGS  one-hot or multi-hot write enable; bit k enables register k
- FunSel  input  3  operation applied to every enabled register
- I  input  WIDTH  write data
- OutASel  input  SELW  read port A select
- OutBSel  input  SELW  read port B select
- OutA  output  WIDTH  contents of register OutASel
- OutB  output  WIDTH  contents of register OutBSel
- Wrap  output  NUM_REGS  sticky wrap/saturation flag per register
- ZeroA  output  1  high when OutA == 0

Behaviour:
- Reset low (asynchronous, any time, including mid-sequence):
  - all registers go to RESET_VAL; Wrap goes to 0.
  - Reset takes effect without a clock edge.
  - Normal operation resumes on the first rising Clock edge after Reset is released.
- Disabled register (RegSel[k]=0): holds its value and Wrap[k].
- Operations on each enabled register, on the rising Clock edge:
  - 000 dec: Q <= Q-1. If Q==0, result wraps to all-ones and Wrap[k] <= 1.
  - 001 inc: Q <= Q+1. If Q==all-ones, result wraps to 0 and Wrap[k] <= 1.
  - 010 load: Q <= I; Wrap[k] <= 0.
  - 011 clear: Q <= 0; Wrap[k] <= 0.
  - 100 clear-high write-low: Q <= {HALF zeros, I[HALF-1:0]}.
  - 101 write low: Q[HALF-1:0] <= I[HALF-1:0]; high half unchanged.
  - 110 write high: Q[WIDTH-1:HALF] <= I[HALF-1:0]; low half unchanged.
  - 111 sign-extend low: Q <= {HALF copies of I[HALF-1], I[HALF-1:0]}.
  - Operations 100–111 leave Wrap[k] unchanged.
- Multi-hot RegSel: every selected register performs the same operation independently. Each register's wrap is evaluated on its own value.
- Read ports:
  - combinational, zero latency; show the pre-edge value during the cycle in which a write occurs.
  - OutASel/OutBSel >= NUM_REGS (non-power-of-two NUM_REGS) return 0.
  - OutASel == OutBSel is legal.
- ZeroA is combinational from OutA.
- Wrap is sticky: set only by a wrapping inc/dec; cleared only by load, clear or reset.

Optional Feature:
- Macro: REG_BANK_SATURATE_EN.
- Defined:
  - inc at all-ones holds all-ones.
  - dec at 0 holds 0.
  - Wrap[k] is set in both cases, meaning "saturation occurred".
- Undefined: modulo-2^WIDTH wrap, as specified above.
- All other operations are identical in both builds.

Decomposition:
- Package reg_bank_pkg holds:
  - FunSel encoding constants: FS_DEC=3'b000, FS_INC, FS_LOAD, FS_CLR, FS_CLRWL, FS_WL, FS_WH, FS_SXL.
  - A typedef for the 3-bit FunSel type.
- Sub-module reg_slice: one WIDTH-bit register plus its Wrap flip-flop.
  - Ports: Clock, Reset, E, FunSel, I, Q, Wrap.
  - reg_bank generates NUM_REGS instances and the two read muxes.

Test Plan:
- Reset: drive Reset low mid-cycle with registers loaded -> all OutA/OutB read 0 and Wrap=0 immediately, no clock edge needed. Release Reset and inc reg0 -> OutA(sel 0)=0x0001.
- Wrap: WIDTH=16, load reg1=0xFFFF, inc -> reg1=0x0000, Wrap[1]=1. Then load 0x1234 -> Wrap[1]=0.
- Half-width ops: load reg2=0xABCD. Write low with I=0x0012 -> 0xAB12. Write high with I=0x0034 -> 0x3412. Sign-extend low with I=0x0080 -> 0xFF80. Clear-write-low with I=0x00FF -> 0x00FF.
- Multi-hot: reg0=0, reg3=5; RegSel=4'b1001, dec -> reg0=0xFFFF with Wrap[0]=1; reg3=4 with Wrap[3]=0.
- Read ports: write reg1 while OutASel=1 -> OutA shows the old value until after the edge. OutASel=OutBSel=1 -> both ports equal. ZeroA=1 when reg1=0.
- REG_BANK_SATURATE_EN defined: dec reg0 at 0 -> stays 0, Wrap[0]=1. Inc at 0xFFFF -> stays 0xFFFF.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared FunSel encodings for the register bank and its per-register slices.
package reg_bank_pkg;

  typedef logic [2:0] funsel_t;

  localparam funsel_t FS_DEC   = 3'b000;
  localparam funsel_t FS_INC   = 3'b001;
  localparam funsel_t FS_LOAD  = 3'b010;
  localparam funsel_t FS_CLR   = 3'b011;
  localparam funsel_t FS_CLRWL = 3'b100;
  localparam funsel_t FS_WL    = 3'b101;
  localparam funsel_t FS_WH    = 3'b110;
  localparam funsel_t FS_SXL   = 3'b111;

endpackage

// File: rtl/reg_slice.sv
// One WIDTH-bit register with a sticky wrap flag; the FunSel operation is applied on the clock edge when E is high.
// REG_BANK_SATURATE_EN: inc/dec clamp at the ends instead of wrapping (Wrap then means "saturated").
module reg_slice
  import reg_bank_pkg::*;
#(
  parameter int              WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             E,
  input  logic [2:0]       FunSel,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] Q,
  output logic             Wrap
);

  localparam int HALF = WIDTH / 2;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_d, q_q;
  logic             wrap_d, wrap_q;

  always_comb begin
    q_d    = q_q;
    wrap_d = wrap_q;
    if (E) begin
      case (FunSel)
        FS_DEC: begin
          if (q_q == '0) begin
            wrap_d = 1'b1;
`ifdef REG_BANK_SATURATE_EN
            q_d = '0;
`else
            q_d = '1;
`endif
          end else begin
            q_d = q_q - ONE;
          end
        end
        FS_INC: begin
          if (q_q == '1) begin
            wrap_d = 1'b1;
`ifdef REG_BANK_SATURATE_EN
            q_d = '1;
`else
            q_d = '0;
`endif
          end else begin
            q_d = q_q + ONE;
          end
        end
        FS_LOAD: begin
          q_d    = I;
          wrap_d = 1'b0;
        end
        FS_CLR: begin
          q_d    = '0;
          wrap_d = 1'b0;
        end
        // Half-width writes below never touch the wrap flag.
        FS_CLRWL: q_d = {{HALF{1'b0}}, I[HALF-1:0]};
        FS_WL:    q_d = {q_q[WIDTH-1:HALF], I[HALF-1:0]};
        FS_WH:    q_d = {I[HALF-1:0], q_q[HALF-1:0]};
        FS_SXL:   q_d = {{HALF{I[HALF-1]}}, I[HALF-1:0]};
        default:  q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      q_q    <= RESET_VAL;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign Q    = q_q;
  assign Wrap = wrap_q;

endmodule

// File: rtl/reg_bank.sv
// NUM_REGS x WIDTH register bank with shared FunSel writes and two combinational read ports.
// Saturating inc/dec selected by REG_BANK_SATURATE_EN (see reg_slice).
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               NUM_REGS  = 4,
  parameter int               SELW      = $clog2(NUM_REGS),
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [NUM_REGS-1:0] RegSel,
  input  logic [2:0]          FunSel,
  input  logic [WIDTH-1:0]    I,
  input  logic [SELW-1:0]     OutASel,
  input  logic [SELW-1:0]     OutBSel,
  output logic [WIDTH-1:0]    OutA,
  output logic [WIDTH-1:0]    OutB,
  output logic [NUM_REGS-1:0] Wrap,
  output logic                ZeroA
);

  logic [WIDTH-1:0] regs [NUM_REGS];

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_slice
    reg_slice #(
      .WIDTH    (WIDTH),
      .RESET_VAL(RESET_VAL)
    ) u_slice (
      .Clock (Clock),
      .Reset (Reset),
      .E     (RegSel[k]),
      .FunSel(FunSel),
      .I     (I),
      .Q     (regs[k]),
      .Wrap  (Wrap[k])
    );
  end

  // Selects that match no register fall through to zero.
  always_comb begin
    OutA = '0;
    OutB = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (OutASel == SELW'(k)) OutA = regs[k];
      if (OutBSel == SELW'(k)) OutB = regs[k];
    end
  end

  assign ZeroA = (OutA == '0);

endmodule
